// File: rtl/pb_event_fsm.sv
// rtl/pb_event_fsm.sv - push-button press/short/long/auto-repeat event classifier
// Optional auto-repeat in HOLD is enabled by defining PB_AUTOREPEAT_EN.
module pb_event_fsm #(
  parameter int LONG_CYC   = 100,
  parameter int REPEAT_CYC = 25,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_debounced,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic rpt_pulse,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  if (LONG_CYC < 2 || LONG_CYC > (1 << CNT_W) - 1) begin : g_bad_long_cyc
    $error("pb_event_fsm: LONG_CYC out of range");
  end
  if (REPEAT_CYC < 1 || REPEAT_CYC > (1 << CNT_W) - 1) begin : g_bad_repeat_cyc
    $error("pb_event_fsm: REPEAT_CYC out of range");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pb_q, pb_d;
  logic             press_q, press_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic             busy_q, busy_d;
  logic             rise;

  assign rise = pb_debounced & ~pb_q;

  always_comb begin
    pb_d    = pb_debounced;
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // cnt counts held edges after the rise edge, so long_pulse lands LONG_CYC edges later
        if (rise) begin
          state_d = PRESS;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESS: begin
        if (!pb_debounced) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!pb_debounced) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
`ifdef PB_AUTOREPEAT_EN
          if (cnt_q == CNT_W'(REPEAT_CYC - 1)) begin
            cnt_d = '0;
            rpt_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pb_q    <= 1'b0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pb_q    <= pb_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      busy_q  <= busy_d;
    end
  end

  assign press_pulse = press_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign rpt_pulse   = rpt_q;
  assign busy        = busy_q;

endmodule
